// File: rtl/cmult_arbiter_if.sv
// ---------------------------------------------------------------------------
// cmult_arbiter_if
//   Bundle of requester, multiplier and result signals around cmult_arbiter.
//
//   Handshake: requester i presents operands with req_valid[i]; the arbiter
//   raises at most one req_ready bit per cycle.  An operand set transfers on
//   the clk edge where req_valid[i] and req_ready[i] are both high.  req_valid
//   must not depend on req_ready.  Results have no backpressure: res_valid[i]
//   is a single-cycle strobe that the owner must accept.
//
//   slave  : arbiter view (drives req_ready, mult_*, res_*, busy)
//   master : surrounding logic view (drives enable, req_*, mult_pr/mult_pi)
// ---------------------------------------------------------------------------
interface cmult_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 3
);
    logic                    enable;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*16-1:0]   req_ar;
    logic [NUM_REQ*16-1:0]   req_ai;
    logic [NUM_REQ*16-1:0]   req_br;
    logic [NUM_REQ*16-1:0]   req_bi;
    logic [15:0]             mult_ar;
    logic [15:0]             mult_ai;
    logic [15:0]             mult_br;
    logic [15:0]             mult_bi;
    logic [32:0]             mult_pr;
    logic [32:0]             mult_pi;
    logic [NUM_REQ-1:0]      res_valid;
    logic [ID_W-1:0]         res_id;
    logic [32:0]             res_pr;
    logic [32:0]             res_pi;
    logic                    busy;

    modport slave (
        input  enable, req_valid, req_ar, req_ai, req_br, req_bi,
        input  mult_pr, mult_pi,
        output req_ready, mult_ar, mult_ai, mult_br, mult_bi,
        output res_valid, res_id, res_pr, res_pi, busy
    );

    modport master (
        output enable, req_valid, req_ar, req_ai, req_br, req_bi,
        output mult_pr, mult_pi,
        input  req_ready, mult_ar, mult_ai, mult_br, mult_bi,
        input  res_valid, res_id, res_pr, res_pi, busy
    );
endinterface

// File: rtl/cmult_arbiter.sv
// ---------------------------------------------------------------------------
// cmult_arbiter
//   Round-robin sharing of one pipelined complex multiplier among NUM_REQ
//   requesters.  One operand set is accepted per cycle and registered into
//   mult_*; an ID tag follows it through a MULT_LATENCY+1 deep shift register
//   so the product coming back on mult_pr/mult_pi is registered into res_*
//   and strobed on res_valid[id] MULT_LATENCY+1 cycles after acceptance.
//
//   Ports:
//     clk          system clock
//     rst          synchronous reset, active low
//     bus          cmult_arbiter_if.slave (enable, req_*, mult_*, res_*, busy)
//     stat_clr     (CMULT_ARB_STATS_EN only) clear all grant counters
//     stat_grants  (CMULT_ARB_STATS_EN only) per-requester 16-bit saturating
//                  grant counters, requester i in bits [16i+15:16i]
//
//   Build option: define CMULT_ARB_STATS_EN to add the grant counters.
// ---------------------------------------------------------------------------
module cmult_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int MULT_LATENCY = 4,
    parameter int ID_W         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef CMULT_ARB_STATS_EN
    input  logic                  stat_clr,
    output logic [NUM_REQ*16-1:0] stat_grants,
`endif
    cmult_arbiter_if.slave        bus
);

    localparam int LAST = MULT_LATENCY;

    logic [ID_W-1:0]    r_ptr;
    logic [LAST:0]      r_tag_vld;
    logic [ID_W-1:0]    r_tag_id [LAST+1];
    logic [15:0]        r_mult_ar;
    logic [15:0]        r_mult_ai;
    logic [15:0]        r_mult_br;
    logic [15:0]        r_mult_bi;
    logic [NUM_REQ-1:0] r_res_valid;
    logic [ID_W-1:0]    r_res_id;
    logic [32:0]        r_res_pr;
    logic [32:0]        r_res_pi;

    logic               w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic [NUM_REQ-1:0] w_ready;
    logic [15:0]        w_ar;
    logic [15:0]        w_ai;
    logic [15:0]        w_br;
    logic [15:0]        w_bi;

    // Round-robin search starting one past the last granted requester.
    // Grants are suppressed while reset is asserted so req_ready never
    // advertises a transfer that the reset edge would discard.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = '0;
        if (bus.enable && rst) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (!w_gnt && bus.req_valid[j] &&
                        (j == (int'(r_ptr) + k) % NUM_REQ)) begin
                        w_gnt    = 1'b1;
                        w_gnt_id = ID_W'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        w_ar    = '0;
        w_ai    = '0;
        w_br    = '0;
        w_bi    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_gnt && (w_gnt_id == ID_W'(j))) begin
                w_ready[j] = 1'b1;
                w_ar       = bus.req_ar[16*j +: 16];
                w_ai       = bus.req_ai[16*j +: 16];
                w_br       = bus.req_br[16*j +: 16];
                w_bi       = bus.req_bi[16*j +: 16];
            end
        end
    end

    // Issue side: operand registers, pointer and tag pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr     <= ID_W'(NUM_REQ - 1);
            r_mult_ar <= '0;
            r_mult_ai <= '0;
            r_mult_br <= '0;
            r_mult_bi <= '0;
            r_tag_vld <= '0;
            for (int i = 0; i <= LAST; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            // Stage 0 aligns with mult_*; stage LAST aligns with mult_pr/pi.
            r_tag_vld   <= {r_tag_vld[LAST-1:0], w_gnt};
            r_tag_id[0] <= w_gnt_id;
            for (int i = 1; i <= LAST; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
            if (w_gnt) begin
                r_ptr     <= w_gnt_id;
                r_mult_ar <= w_ar;
                r_mult_ai <= w_ai;
                r_mult_br <= w_br;
                r_mult_bi <= w_bi;
            end
        end
    end

    // Return side: capture the product while its tag sits in the last stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_res_valid <= '0;
            r_res_id    <= '0;
            r_res_pr    <= '0;
            r_res_pi    <= '0;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                r_res_valid[j] <= r_tag_vld[LAST] && (r_tag_id[LAST] == ID_W'(j));
            end
            if (r_tag_vld[LAST]) begin
                r_res_id <= r_tag_id[LAST];
                r_res_pr <= bus.mult_pr;
                r_res_pi <= bus.mult_pi;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.mult_ar   = r_mult_ar;
    assign bus.mult_ai   = r_mult_ai;
    assign bus.mult_br   = r_mult_br;
    assign bus.mult_bi   = r_mult_bi;
    assign bus.res_valid = r_res_valid;
    assign bus.res_id    = r_res_id;
    assign bus.res_pr    = r_res_pr;
    assign bus.res_pi    = r_res_pi;
    assign bus.busy      = (|r_tag_vld) || (|w_ready);

`ifdef CMULT_ARB_STATS_EN
    logic [15:0] r_stat [NUM_REQ];

    // Clear wins over a same-cycle grant; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst || stat_clr) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                r_stat[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (w_ready[j] && (r_stat[j] != 16'hFFFF)) begin
                    r_stat[j] <= r_stat[j] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            stat_grants[16*j +: 16] = r_stat[j];
        end
    end
`endif

endmodule

// File: tb/tb_cmult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cmult_arbiter
//   Bench for cmult_arbiter with a behavioural multiplier, a round-robin /
//   latency model with expected-result queue, and directed scenarios with
//   hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cmult_arbiter;

    localparam int NR  = 2;
    localparam int LAT = 4;
    localparam int IW  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cmult_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus();

`ifdef CMULT_ARB_STATS_EN
    logic              stat_clr = 1'b0;
    logic [NR*16-1:0]  stat_grants;
`endif

    cmult_arbiter #(.NUM_REQ(NR), .MULT_LATENCY(LAT), .ID_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CMULT_ARB_STATS_EN
        .stat_clr    (stat_clr),
        .stat_grants (stat_grants),
`endif
        .bus         (bus)
    );

    // ---------------- complex arithmetic ----------------
    function automatic logic [32:0] c_re(input logic [15:0] ar, ai, br, bi);
        longint v;
        v = longint'($signed(ar)) * longint'($signed(br))
          - longint'($signed(ai)) * longint'($signed(bi));
        return v[32:0];
    endfunction

    function automatic logic [32:0] c_im(input logic [15:0] ar, ai, br, bi);
        longint v;
        v = longint'($signed(ar)) * longint'($signed(bi))
          + longint'($signed(ai)) * longint'($signed(br));
        return v[32:0];
    endfunction

    // ---------------- multiplier stand-in (LAT register stages) ----------------
    logic [32:0] mp_pr [LAT] = '{default: '0};
    logic [32:0] mp_pi [LAT] = '{default: '0};
    always @(posedge clk) begin
        mp_pr[0] <= c_re(bus.mult_ar, bus.mult_ai, bus.mult_br, bus.mult_bi);
        mp_pi[0] <= c_im(bus.mult_ar, bus.mult_ai, bus.mult_br, bus.mult_bi);
        for (int i = 1; i < LAT; i++) begin
            mp_pr[i] <= mp_pr[i-1];
            mp_pi[i] <= mp_pi[i-1];
        end
    end
    assign bus.mult_pr = mp_pr[LAT-1];
    assign bus.mult_pi = mp_pi[LAT-1];

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- model + scoreboard ----------------
    typedef struct packed {
        int          acc;
        int          due;
        logic [IW-1:0] id;
        logic [32:0] pr;
        logic [32:0] pi;
    } exp_t;

    exp_t        exp_q[$];
    int          m_ptr = NR - 1;
    logic [NR-1:0] m_valid;
    logic [IW-1:0] m_id = '0;
    logic [32:0] m_pr = '0;
    logic [32:0] m_pi = '0;

    // Logs of what the DUT actually did, for the directed expectations.
    int     gnt_log[$];
    int     gnt_cyc[$];
    int     res_id_log[$];
    longint res_pr_log[$];
    longint res_pi_log[$];
    int     res_cyc[$];

    function automatic int rr_pick(input int ptr, input logic [NR-1:0] v);
        int i;
        for (int k = 1; k <= NR; k++) begin
            i = (ptr + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [NR-1:0] exp_ready;
        bit exp_busy;
        exp_t it;

        // retire the result due at this cycle
        m_valid = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            it      = exp_q.pop_front();
            m_valid = NR'(1) << it.id;
            m_id    = it.id;
            m_pr    = it.pr;
            m_pi    = it.pi;
        end

        g         = (rst && bus.enable) ? rr_pick(m_ptr, bus.req_valid) : -1;
        exp_ready = (g >= 0) ? (NR'(1) << g) : '0;
        exp_busy  = (g >= 0) || (exp_q.size() > 0 && exp_q[0].acc <= cyc);

        chk("req_ready", bus.req_ready, exp_ready);
        chk("res_valid", bus.res_valid, m_valid);
        chk("res_id",    bus.res_id,    m_id);
        chk("res_pr",    longint'($signed(bus.res_pr)), longint'($signed(m_pr)));
        chk("res_pi",    longint'($signed(bus.res_pi)), longint'($signed(m_pi)));
        chk("busy",      bus.busy,      exp_busy);

        for (int i = 0; i < NR; i++) begin
            if (bus.req_ready[i] && bus.req_valid[i]) begin
                gnt_log.push_back(i);
                gnt_cyc.push_back(cyc + 1);
            end
            if (bus.res_valid[i]) begin
                res_id_log.push_back(i);
                res_pr_log.push_back(longint'($signed(bus.res_pr)));
                res_pi_log.push_back(longint'($signed(bus.res_pi)));
                res_cyc.push_back(cyc);
            end
        end

        // effect of the coming edge
        if (!rst) begin
            exp_q.delete();
            m_ptr = NR - 1;
            m_id  = '0;
            m_pr  = '0;
            m_pi  = '0;
        end else if (g >= 0) begin
            m_ptr  = g;
            it.acc = cyc + 1;
            it.due = cyc + 1 + LAT + 1;
            it.id  = IW'(g);
            it.pr  = c_re(bus.req_ar[16*g +: 16], bus.req_ai[16*g +: 16],
                          bus.req_br[16*g +: 16], bus.req_bi[16*g +: 16]);
            it.pi  = c_im(bus.req_ar[16*g +: 16], bus.req_ai[16*g +: 16],
                          bus.req_br[16*g +: 16], bus.req_bi[16*g +: 16]);
            exp_q.push_back(it);
        end
    end

    // ---------------- driver ----------------
    logic [63:0] ops_mem [NR][64];
    int          ops_head [NR] = '{default: 0};
    int          ops_tail [NR] = '{default: 0};

    task automatic push_op(input int r, input int ar, input int ai, input int br, input int bi);
        ops_mem[r][ops_tail[r]] = {16'(ar), 16'(ai), 16'(br), 16'(bi)};
        ops_tail[r]++;
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < NR; r++) if (ops_head[r] != ops_tail[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_inputs();
        logic [63:0] op;
        for (int r = 0; r < NR; r++) begin
            op = (ops_head[r] != ops_tail[r]) ? ops_mem[r][ops_head[r]] : '0;
            bus.req_valid[r]         = (ops_head[r] != ops_tail[r]);
            bus.req_ar[16*r +: 16]   = op[63:48];
            bus.req_ai[16*r +: 16]   = op[47:32];
            bus.req_br[16*r +: 16]   = op[31:16];
            bus.req_bi[16*r +: 16]   = op[15:0];
        end
    endtask

    task automatic flush_ops();
        for (int r = 0; r < NR; r++) begin
            ops_head[r] = 0;
            ops_tail[r] = 0;
        end
        set_inputs();
    endtask

    // Presents queued ops until drained (or stop_grants reached); bounded.
    task automatic drive(input int max_cyc, input int stop_grants);
        int n = 0;
        int g = 0;
        logic [NR-1:0] fired;
        while (n < max_cyc && !all_empty() && (stop_grants == 0 || g < stop_grants)) begin
            set_inputs();
            @(negedge clk);
            fired = bus.req_ready & bus.req_valid;
            @(posedge clk); #1;
            for (int r = 0; r < NR; r++) begin
                if (fired[r]) begin
                    ops_head[r]++;
                    g++;
                end
            end
            n++;
        end
        set_inputs();
        if (n >= max_cyc) begin
            n_checks++;
            $display("FAIL drive_timeout: got %0d grants after %0d cycles", g, n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    task automatic clr_logs();
        gnt_log.delete(); gnt_cyc.delete();
        res_id_log.delete(); res_pr_log.delete(); res_pi_log.delete(); res_cyc.delete();
    endtask

    // ---------------- directed scenarios ----------------
    int exp_order [6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        bus.enable    = 1'b0;
        bus.req_valid = '0;
        bus.req_ar    = '0;
        bus.req_ai    = '0;
        bus.req_br    = '0;
        bus.req_bi    = '0;
        idle(2);

        // reset state
        chk("rst_mult_ar", bus.mult_ar, 0);
        chk("rst_mult_bi", bus.mult_bi, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_pr", bus.res_pr, 0);
        chk("rst_busy", bus.busy, 0);
        rst        = 1'b1;
        bus.enable = 1'b1;

        // single op: (400+100j)*(200+1000j) = -20000 + 420000j
        clr_logs();
        push_op(0, 400, 100, 200, 1000);
        drive(20, 0);
        idle(8);
        chk("t1_nres", res_id_log.size(), 1);
        if (res_id_log.size() == 1 && gnt_cyc.size() == 1) begin
            chk("t1_id", res_id_log[0], 0);
            chk("t1_pr", res_pr_log[0], -20000);
            chk("t1_pi", res_pi_log[0], 420000);
            chk("t1_latency", res_cyc[0] - gnt_cyc[0], 5);
        end

        // contention: both requesters continuously valid
        do_reset();
        clr_logs();
        for (int i = 0; i < 3; i++) begin
            push_op(0, i + 1, 2, 3, -i);
            push_op(1, -7, i, 5, 9);
        end
        drive(40, 0);
        idle(8);
        chk("t2_ngnt", gnt_log.size(), 6);
        chk("t2_nres", res_id_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size() && i < res_id_log.size(); i++) begin
            chk("t2_gnt_order", gnt_log[i], exp_order[i]);
            chk("t2_res_order", res_id_log[i], exp_order[i]);
        end

        // back-to-back from requester 1: (n)*(3) -> pr = 3n
        do_reset();
        clr_logs();
        for (int i = 1; i <= 8; i++) push_op(1, i, 0, 3, 0);
        drive(40, 0);
        idle(8);
        chk("t3_nres", res_id_log.size(), 8);
        for (int i = 0; i < res_id_log.size() && i < 8; i++) begin
            chk("t3_id", res_id_log[i], 1);
            chk("t3_pr", res_pr_log[i], 3 * (i + 1));
            if (i > 0) chk("t3_gap", res_cyc[i] - res_cyc[i-1], 1);
        end

        // enable drop after 3 accepted ops, requests stay asserted
        do_reset();
        clr_logs();
        for (int i = 0; i < 10; i++) push_op(0, 10 + i, -3, 4, 2);
        drive(40, 3);
        bus.enable = 1'b0;
        idle(12);
        chk("t4_ngnt", gnt_log.size(), 3);
        chk("t4_nres", res_id_log.size(), 3);
        chk("t4_ready_off", bus.req_ready, 0);
        chk("t4_busy_low", bus.busy, 0);
        flush_ops();
        bus.enable = 1'b1;

        // reset while two ops are in flight; requester 0 first afterwards
        do_reset();
        clr_logs();
        push_op(0, 11, 22, 33, 44);
        push_op(0, -5, 6, -7, 8);
        drive(20, 0);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(10);
        chk("t5_ngnt_pre", gnt_log.size(), 2);
        chk("t5_nres", res_id_log.size(), 0);
        clr_logs();
        push_op(0, 1, 1, 1, 1);
        push_op(1, 2, 2, 2, 2);
        drive(20, 0);
        idle(8);
        chk("t5_ngnt_post", gnt_log.size(), 2);
        if (gnt_log.size() > 0) chk("t5_first", gnt_log[0], 0);
        chk("t5_nres_post", res_id_log.size(), 2);

`ifdef CMULT_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) push_op(0, i, 1, 2, 3);
        for (int i = 0; i < 3; i++) push_op(1, i, 4, 5, 6);
        drive(40, 0);
        chk("st_req0", stat_grants[15:0], 5);
        chk("st_req1", stat_grants[31:16], 3);
        stat_clr = 1'b1;
        push_op(0, 9, 9, 9, 9);
        drive(20, 0);
        stat_clr = 1'b0;
        chk("st_clr0", stat_grants[15:0], 0);
        chk("st_clr1", stat_grants[31:16], 0);
        idle(8);
`endif

        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
